// File: rtl/iter_right_shifter_pkg.sv
// Shared types and constants for the iterative right shifter/rotator.
// The state encoding and the mode values are fixed here so that any block or bench can rely on them.
package iter_right_shifter_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_AMT_W = 3;

  localparam logic MODE_ROR = 1'b0;
  localparam logic MODE_LSR = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/iter_right_shifter_shr_step.sv
// Combinational single-position right step.
// The bit vacated at the MSB is filled either with the old LSB (rotate) or with zero (logical shift).
module shr_step
  import iter_right_shifter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] d,
  input  logic             mode,
  output logic [WIDTH-1:0] q
);

  logic fill;

  assign fill = (mode == MODE_LSR) ? 1'b0 : d[0];
  assign q    = {fill, d[WIDTH-1:1]};

endmodule

// File: rtl/iter_right_shifter.sv
// Sequential right shifter/rotator with valid/ready on both sides.
// It moves the operand one bit position per clock, so a shift by amt takes amt cycles in SHIFT.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | in_ready high; waiting for an operand
// ST_SHIFT | one right step per edge; cnt holds the steps still to do
// ST_DONE  | out_valid high; result held until the sink takes it
module iter_right_shifter
  import iter_right_shifter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int AMT_W = DEF_AMT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [WIDTH-1:0] step_q;

  shr_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .d   (data_q),
    .mode(mode_q),
    .q   (step_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= MODE_ROR;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          mode_d  = in_mode;
          cnt_d   = in_amt;
          state_d = (in_amt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        data_d = step_q;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == AMT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // data_q is frozen outside SHIFT, so it doubles as the held output register.
  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign out_data  = data_q;

endmodule

// File: tb/tb_iter_right_shifter.sv
// Bench for iter_right_shifter: directed cases with literal results plus randomized traffic,
// all checked every cycle against a timing/result model built from edge counts and plain arithmetic.
module tb_iter_right_shifter;

  localparam int W = 8;
  localparam int A = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic [A-1:0] in_amt;
  logic         in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  int n_vec  = 0;
  int n_fail = 0;

  iter_right_shifter #(.WIDTH(W), .AMT_W(A)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_amt   (in_amt),
    .in_mode  (in_mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ref_fn(input logic [W-1:0] d, input logic [A-1:0] a, input logic m);
    logic [2*W-1:0] t;
    t = {d, d} >> a;
    if (m) return d >> a;
    return t[W-1:0];
  endfunction

  // Model: an accepted operand becomes visible amt edges after its accept edge,
  // i.e. on the (amt+1)-th edge counting the accept edge itself.
  int           edges      = 0;
  int           valid_edge = 0;
  bit           m_busy     = 1'b0;
  bit           m_zero     = 1'b0;
  bit           started    = 1'b0;
  logic [W-1:0] m_res      = '0;

  function automatic bit exp_valid();
    return m_busy && (edges >= valid_edge);
  endfunction

  always @(posedge clk) begin
    bit was_valid;
    was_valid = exp_valid();
    edges++;
    if (rst) begin
      m_busy  = 1'b0;
      m_zero  = 1'b1;
      started = 1'b1;
    end else if (!m_busy) begin
      if (in_valid && started) begin
        m_busy     = 1'b1;
        m_zero     = 1'b0;
        m_res      = ref_fn(in_data, in_amt, in_mode);
        valid_edge = edges + int'(in_amt);
      end
    end else if (was_valid && out_ready) begin
      m_busy = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", in_ready, !m_busy && !rst);
      chk("out_valid", out_valid, exp_valid());
      if (exp_valid()) chk("out_data", out_data, m_res);
      else if (m_zero && !m_busy) chk("out_data_cleared", out_data, '0);
    end
  end

  task automatic op(input logic [W-1:0] d, input logic [A-1:0] a, input logic m,
                    input int hold, input logic [W-1:0] exp, input string nm);
    bit acc;
    int n;
    in_data   = d;
    in_amt    = a;
    in_mode   = m;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      chk({nm, "_accept_timeout"}, 0, 1);
      in_valid = 1'b0;
      return;
    end
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({nm, "_latency"}, n, int'(a) + 1);
    chk({nm, "_data"}, out_data, exp);
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = ~d;
      @(posedge clk);
      #1;
      chk({nm, "_hold_data"}, out_data, exp);
      chk({nm, "_hold_valid"}, out_valid, 1);
      chk({nm, "_hold_ready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({nm, "_post_valid"}, out_valid, 0);
    chk({nm, "_post_ready"}, in_ready, 1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_amt    = '0;
    in_mode   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    op(8'h87, 3'd3, 1'b0, 0, 8'hF0, "ror_87_3");
    op(8'hA5, 3'd0, 1'b0, 0, 8'hA5, "zero_amt");
    op(8'hF0, 3'd7, 1'b1, 0, 8'h01, "lsr_max");
    op(8'hF0, 3'd7, 1'b0, 0, 8'hE1, "ror_max");
    op(8'h0F, 3'd2, 1'b0, 5, 8'hC3, "backpressure");

    // abort mid-operation: reset lands on the third SHIFT edge
    in_data  = 8'hF0;
    in_amt   = 3'd6;
    in_mode  = 1'b0;
    in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    chk("midrst_in_ready", in_ready, 0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("midrst_no_spurious", out_valid, 0);
    end

    for (int m = 0; m < 2; m++)
      for (int a = 0; a < W; a++)
        op(8'hF0, A'(a), m[0], 0, ref_fn(8'hF0, A'(a), m[0]), "sweep");

    for (int i = 0; i < 1500; i++) begin
      @(posedge clk);
      #1;
      rst       = ($urandom_range(0, 199) == 0);
      in_valid  = $urandom_range(0, 2) != 0;
      in_data   = W'($urandom);
      in_amt    = A'($urandom);
      in_mode   = $urandom_range(0, 1) != 0;
      out_ready = $urandom_range(0, 3) != 0;
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
